// File: rtl/angle_sched_pkg.sv
// angle_sched_pkg: shared types for the angle sensor SPI scheduler.
// FSM state encoding, chip-select phase lengths, sensor index type.
package angle_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CS_SETUP,
    S_START,
    S_WAIT_DONE,
    S_CS_HOLD,
    S_STORE
  } state_t;

  localparam int CS_SETUP_CYC = 1;
  localparam int CS_HOLD_CYC  = 1;

  typedef logic [1:0] sens_idx_t;

endpackage

// File: rtl/angle_spi_scheduler_rr_mask_picker.sv
// rr_mask_picker: lowest enabled, not-yet-polled sensor index >= ptr.
// Ports: mask, done (per-sensor bits), ptr -> idx, found.
module rr_mask_picker
  import angle_sched_pkg::*;
#(
  parameter int NUM_SENSORS = 4
) (
  input  logic [NUM_SENSORS-1:0] mask,
  input  logic [NUM_SENSORS-1:0] done,
  input  sens_idx_t              ptr,
  output sens_idx_t              idx,
  output logic                   found
);

  // Scan downwards so the lowest qualifying index wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask[i] && !done[i] && i >= int'(ptr)) begin
        idx   = sens_idx_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/angle_spi_scheduler.sv
// angle_spi_scheduler: shares one SPI master between periodic angle
// polls of up to 4 sensors and host command writes.
// Ports: clk/reset, enable, sensor_mask, cmd_* host request,
//   spi_* master handshake, angle_ss_n_o chip selects,
//   angle_* poll result, sweep_done pulse, sticky timeout_err.
module angle_spi_scheduler
  import angle_sched_pkg::*;
#(
  parameter int              NUM_SENSORS = 4,
  parameter int              DATA_W      = 16,
  parameter int              POLL_PERIOD = 50000,
  parameter int              TIMEOUT     = 1023,
  parameter logic [DATA_W-1:0] READ_CMD  = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_sensor,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic                   spi_start,
  output logic [DATA_W-1:0]      spi_tx_data,
  input  logic                   spi_done,
  input  logic [DATA_W-1:0]      spi_rx_data,
  output logic [NUM_SENSORS-1:0] angle_ss_n_o,
  output logic                   angle_valid,
  output logic [1:0]             angle_sensor,
  output logic [DATA_W-1:0]      angle_data,
  output logic                   sweep_done,
  output logic                   timeout_err
);

  localparam int TW  = $clog2(POLL_PERIOD);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int PHW = 2;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q;
  logic [TCW-1:0]         to_cnt_q;
  logic [PHW-1:0]         ph_cnt_q;
  logic                   sweep_pending_q;
  sens_idx_t              ptr_q;
  sens_idx_t              sel_q;
  logic [NUM_SENSORS-1:0] done_q;
  logic                   is_host_q;
  logic [DATA_W-1:0]      tx_q;
  logic [DATA_W-1:0]      rx_q;
  logic                   sweep_done_q;
  logic                   timeout_err_q;

  logic      tick;
  logic      ss_on;
  logic      accept_host;
  logic      accept_poll;
  logic      end_sweep;
  logic      to_abort;
  logic      cmd_in_range;
  sens_idx_t pick_idx;
  logic      pick_found;

  assign tick = enable && (timer_q == TW'(POLL_PERIOD - 1));
  assign cmd_in_range = int'(cmd_sensor) < NUM_SENSORS;

  rr_mask_picker #(
    .NUM_SENSORS(NUM_SENSORS)
  ) u_picker (
    .mask  (sensor_mask),
    .done  (done_q),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    spi_start   = 1'b0;
    angle_valid = 1'b0;
    ss_on       = 1'b0;
    accept_host = 1'b0;
    accept_poll = 1'b0;
    end_sweep   = 1'b0;
    to_abort    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_pending_q || tick || cmd_valid)
          state_d = S_ARB;
      end
      S_ARB: begin
        if (cmd_valid) begin
          cmd_ready   = 1'b1;
          accept_host = 1'b1;
          // Out-of-range targets are acknowledged and dropped.
          if (cmd_in_range)
            state_d = S_CS_SETUP;
        end else if (sweep_pending_q && pick_found) begin
          accept_poll = 1'b1;
          state_d     = S_CS_SETUP;
        end else begin
          end_sweep = sweep_pending_q;
          state_d   = S_IDLE;
        end
      end
      S_CS_SETUP: begin
        ss_on = 1'b1;
        if (ph_cnt_q == PHW'(CS_SETUP_CYC - 1))
          state_d = S_START;
      end
      S_START: begin
        ss_on     = 1'b1;
        spi_start = 1'b1;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        ss_on = 1'b1;
        if (spi_done) begin
          state_d = S_CS_HOLD;
        end else if (to_cnt_q >= TCW'(TIMEOUT - 1)) begin
          to_abort = 1'b1;
          state_d  = S_ARB;
        end
      end
      S_CS_HOLD: begin
        ss_on = 1'b1;
        if (ph_cnt_q == PHW'(CS_HOLD_CYC - 1))
          state_d = S_STORE;
      end
      S_STORE: begin
        angle_valid = !is_host_q;
        state_d     = S_ARB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      to_cnt_q        <= '0;
      ph_cnt_q        <= '0;
      sweep_pending_q <= 1'b0;
      ptr_q           <= '0;
      sel_q           <= '0;
      done_q          <= '0;
      is_host_q       <= 1'b0;
      tx_q            <= '0;
      rx_q            <= '0;
      sweep_done_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_done_q <= end_sweep;

      if (!enable || tick)
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;

      // Ticks coalesce into one pending bit; a tick that lands on
      // the end-of-sweep cycle is an overrun and is dropped.
      if (tick)
        sweep_pending_q <= 1'b1;
      if (end_sweep) begin
        sweep_pending_q <= 1'b0;
        ptr_q           <= '0;
        done_q          <= '0;
      end

      if (accept_host) begin
        sel_q     <= cmd_sensor;
        tx_q      <= cmd_data;
        is_host_q <= 1'b1;
      end else if (accept_poll) begin
        sel_q     <= pick_idx;
        tx_q      <= READ_CMD;
        is_host_q <= 1'b0;
      end

      ph_cnt_q <= (state_d != state_q) ? '0 : ph_cnt_q + 1'b1;

      // Counts cycles elapsed since the spi_start cycle.
      if (state_q == S_START)
        to_cnt_q <= TCW'(1);
      else if (state_q == S_WAIT_DONE)
        to_cnt_q <= to_cnt_q + 1'b1;

      if (state_q == S_WAIT_DONE && spi_done)
        rx_q <= spi_rx_data;

      if (to_abort)
        timeout_err_q <= 1'b1;

      // A timed-out poll still counts as visited for this sweep.
      if (!is_host_q && (angle_valid || to_abort)) begin
        done_q[sel_q] <= 1'b1;
        ptr_q         <= sel_q + 2'd1;
      end
    end
  end

  assign angle_ss_n_o = ss_on ? ~(NUM_SENSORS'(1) << sel_q) : '1;
  assign spi_tx_data  = tx_q;
  assign angle_sensor = sel_q;
  assign angle_data   = rx_q;
  assign sweep_done   = sweep_done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_angle_spi_scheduler.sv
// tb_angle_spi_scheduler: directed scoreboard bench for the scheduler.
// SPI master is modelled in the bench; results checked against queues.
module tb_angle_spi_scheduler;

  localparam int NS  = 4;
  localparam int DW  = 16;
  localparam int PP  = 100;
  localparam int TO  = 15;
  localparam int LAT = 2;

  typedef struct packed {
    logic [NS-1:0] ss;
    logic [DW-1:0] tx;
  } xfer_t;

  typedef struct packed {
    logic [1:0]    sen;
    logic [DW-1:0] data;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NS-1:0] sensor_mask = '0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_sensor = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic          spi_done = 1'b0;
  logic [DW-1:0] spi_rx_data = '0;
  logic [NS-1:0] angle_ss_n_o;
  logic          angle_valid;
  logic [1:0]    angle_sensor;
  logic [DW-1:0] angle_data;
  logic          sweep_done;
  logic          timeout_err;

  logic          cmd_valid3 = 1'b0;
  logic [1:0]    cmd_sensor3 = '0;
  logic          cmd_ready3;
  logic          spi_start3;
  logic [DW-1:0] spi_tx_data3;
  logic [2:0]    angle_ss_n_o3;
  logic          angle_valid3;
  logic [1:0]    angle_sensor3;
  logic [DW-1:0] angle_data3;
  logic          sweep_done3;
  logic          timeout_err3;

  angle_spi_scheduler #(
    .NUM_SENSORS(NS), .DATA_W(DW), .POLL_PERIOD(PP),
    .TIMEOUT(TO), .READ_CMD(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sensor_mask(sensor_mask), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_sensor(cmd_sensor),
    .cmd_data(cmd_data), .spi_start(spi_start),
    .spi_tx_data(spi_tx_data), .spi_done(spi_done),
    .spi_rx_data(spi_rx_data), .angle_ss_n_o(angle_ss_n_o),
    .angle_valid(angle_valid), .angle_sensor(angle_sensor),
    .angle_data(angle_data), .sweep_done(sweep_done),
    .timeout_err(timeout_err)
  );

  angle_spi_scheduler #(
    .NUM_SENSORS(3), .DATA_W(DW), .POLL_PERIOD(PP),
    .TIMEOUT(TO), .READ_CMD(16'hFFFF)
  ) dut3 (
    .clk(clk), .reset(reset), .enable(1'b0),
    .sensor_mask(3'b000), .cmd_valid(cmd_valid3),
    .cmd_ready(cmd_ready3), .cmd_sensor(cmd_sensor3),
    .cmd_data(16'h1111), .spi_start(spi_start3),
    .spi_tx_data(spi_tx_data3), .spi_done(1'b0),
    .spi_rx_data(16'h0000), .angle_ss_n_o(angle_ss_n_o3),
    .angle_valid(angle_valid3), .angle_sensor(angle_sensor3),
    .angle_data(angle_data3), .sweep_done(sweep_done3),
    .timeout_err(timeout_err3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  xfer_t xq[$];
  res_t  rq[$];
  xfer_t exp_x;
  res_t  exp_r;

  logic [NS-1:0] withhold = '0;
  logic [DW-1:0] rx_word = '0;
  logic          hold = 1'b0;
  int lat = 0;
  int n_start = 0, first_start_cyc = 0;
  int n_sweep = 0, last_sweep_cyc = 0;
  int n_ready = 0, ready_cyc = 0;
  int valid_cyc[NS];
  logic to_seen = 1'b0;
  int to_cyc = 0;
  logic [NS-1:0] ss_at_to = '0;
  int n_ready3 = 0, n_start3 = 0;
  logic ss3_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI master model, scoreboard consumer and event recorder.
  always @(negedge clk) begin
    if (reset) begin
      lat      = 0;
      spi_done = 1'b0;
    end else begin
      spi_done = 1'b0;
      if (spi_start) begin
        if (n_start == 0) first_start_cyc = cyc;
        n_start++;
        chk("xfer_expected", 32'(xq.size() > 0), 32'd1);
        if (xq.size() > 0) begin
          exp_x = xq.pop_front();
          chk("xfer_ss_tx", 32'({angle_ss_n_o, spi_tx_data}), 32'(exp_x));
        end
        hold = |(withhold & ~angle_ss_n_o);
        lat  = LAT;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0 && !hold) begin
          spi_done    = 1'b1;
          spi_rx_data = rx_word;
        end
      end
      if (angle_valid) begin
        valid_cyc[angle_sensor] = cyc;
        chk("result_expected", 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) begin
          exp_r = rq.pop_front();
          chk("angle_result", 32'({angle_sensor, angle_data}), 32'(exp_r));
        end
      end
      if (sweep_done) begin
        n_sweep++;
        last_sweep_cyc = cyc;
      end
      if (cmd_ready) begin
        n_ready++;
        ready_cyc = cyc;
      end
      if (timeout_err && !to_seen) begin
        to_seen  = 1'b1;
        to_cyc   = cyc;
        ss_at_to = angle_ss_n_o;
      end
      chk("ss_onehot", 32'($countones(~angle_ss_n_o) <= 1), 32'd1);
      if (cmd_ready3) n_ready3++;
      if (spi_start3) n_start3++;
      if (angle_ss_n_o3 != 3'b111) ss3_low = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    sensor_mask = '0;
    cmd_valid   = 1'b0;
    withhold    = '0;
    repeat (3) step();
    xq.delete();
    rq.delete();
    n_start = 0;
    n_sweep = 0;
    n_ready = 0;
    to_seen = 1'b0;
    reset   = 1'b0;
    step();
  endtask

  task automatic wait_sweeps(input int target, input int budget,
                             input string tag);
    int k = 0;
    while (n_sweep < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(n_sweep), 32'(target));
  endtask

  task automatic push_poll(input int i, input logic [DW-1:0] d);
    logic [NS-1:0] s;
    s    = '1;
    s[i] = 1'b0;
    xq.push_back({s, 16'hFFFF});
    rq.push_back({2'(i), d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en;
    int k;
    logic [NS-1:0] s;

    // Reset state
    repeat (3) step();
    chk("rst_ss", 32'(angle_ss_n_o), 32'hF);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_tx", 32'(spi_tx_data), 32'd0);
    chk("rst_valid", 32'(angle_valid), 32'd0);
    chk("rst_sensor", 32'(angle_sensor), 32'd0);
    chk("rst_data", 32'(angle_data), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_ss3", 32'(angle_ss_n_o3), 32'h7);
    do_reset();

    // Full mask, two sweeps one period apart
    rx_word     = 16'h1234;
    sensor_mask = 4'b1111;
    for (int i = 0; i < NS; i++) push_poll(i, 16'h1234);
    en     = cyc;
    enable = 1'b1;
    wait_sweeps(1, 250, "t1_sweep1");
    chk("t1_first_start", 32'(first_start_cyc), 32'(en + 102));
    chk("t1_sweep_cyc", 32'(last_sweep_cyc), 32'(en + 129));
    chk("t1_q_empty", 32'(xq.size() + rq.size()), 32'd0);
    k = last_sweep_cyc;
    for (int i = 0; i < NS; i++) push_poll(i, 16'h1234);
    wait_sweeps(2, 150, "t1_sweep2");
    chk("t1_period", 32'(last_sweep_cyc - k), 32'(PP));
    chk("t1_q2_empty", 32'(xq.size() + rq.size()), 32'd0);
    do_reset();

    // Sparse mask 1010
    rx_word     = 16'hBEEF;
    sensor_mask = 4'b1010;
    push_poll(1, 16'hBEEF);
    push_poll(3, 16'hBEEF);
    en     = cyc;
    enable = 1'b1;
    wait_sweeps(1, 250, "t2_sweep");
    chk("t2_tick_to_start", 32'(first_start_cyc), 32'(en + 102));
    chk("t2_sweep_cyc", 32'(last_sweep_cyc), 32'(en + 115));
    chk("t2_q_empty", 32'(xq.size() + rq.size()), 32'd0);
    do_reset();

    // Host write interleaved after the sensor-1 read
    rx_word     = 16'h1234;
    sensor_mask = 4'b1111;
    push_poll(0, 16'h1234);
    push_poll(1, 16'h1234);
    xq.push_back({4'b1011, 16'hA5A5});
    push_poll(2, 16'h1234);
    push_poll(3, 16'h1234);
    en     = cyc;
    enable = 1'b1;
    k = 0;
    while (n_start < 2 && k < 250) begin step(); k++; end
    chk("t3_reach_s1", 32'(n_start), 32'd2);
    cmd_sensor = 2'd2;
    cmd_data   = 16'hA5A5;
    cmd_valid  = 1'b1;
    k = 0;
    while (n_ready < 1 && k < 50) begin step(); k++; end
    chk("t3_ready_seen", 32'(n_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("t3_ready_after_store", 32'(ready_cyc), 32'(valid_cyc[1] + 1));
    chk("t3_ready_cyc", 32'(ready_cyc), 32'(en + 114));
    wait_sweeps(1, 150, "t3_sweep");
    chk("t3_sweep_cyc", 32'(last_sweep_cyc), 32'(en + 136));
    chk("t3_q_empty", 32'(xq.size() + rq.size()), 32'd0);
    chk("t3_one_ready", 32'(n_ready), 32'd1);
    do_reset();

    // Sensor 0 never answers
    rx_word     = 16'h0F0F;
    sensor_mask = 4'b0011;
    withhold    = 4'b0001;
    s = 4'b1110;
    xq.push_back({s, 16'hFFFF});
    push_poll(1, 16'h0F0F);
    en     = cyc;
    enable = 1'b1;
    wait_sweeps(1, 250, "t4_sweep");
    chk("t4_to_seen", 32'(to_seen), 32'd1);
    chk("t4_to_cyc", 32'(to_cyc), 32'(first_start_cyc + TO));
    chk("t4_ss_at_to", 32'(ss_at_to), 32'hF);
    chk("t4_q_empty", 32'(xq.size() + rq.size()), 32'd0);
    chk("t4_sticky", 32'(timeout_err), 32'd1);
    do_reset();
    chk("t4_cleared", 32'(timeout_err), 32'd0);

    // Empty mask
    sensor_mask = 4'b0000;
    en     = cyc;
    enable = 1'b1;
    wait_sweeps(1, 250, "t5_sweep");
    chk("t5_sweep_cyc", 32'(last_sweep_cyc), 32'(en + 101));
    repeat (20) step();
    chk("t5_no_start", 32'(n_start), 32'd0);
    do_reset();

    // Reset while waiting for the master
    sensor_mask = 4'b1111;
    withhold    = 4'b1111;
    s = 4'b1110;
    xq.push_back({s, 16'hFFFF});
    enable = 1'b1;
    k = 0;
    while (n_start < 1 && k < 250) begin step(); k++; end
    chk("t6_started", 32'(n_start), 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("t6_ss", 32'(angle_ss_n_o), 32'hF);
    chk("t6_start", 32'(spi_start), 32'd0);
    chk("t6_valid", 32'(angle_valid), 32'd0);
    chk("t6_sweep_done", 32'(sweep_done), 32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd0);
    do_reset();

    // Out-of-range host target on a 3-sensor instance
    cmd_sensor3 = 2'd3;
    cmd_valid3  = 1'b1;
    k = 0;
    while (n_ready3 < 1 && k < 20) begin step(); k++; end
    @(posedge clk);
    #1;
    cmd_valid3 = 1'b0;
    repeat (10) step();
    chk("t6_oor_ready", 32'(n_ready3), 32'd1);
    chk("t6_oor_no_start", 32'(n_start3), 32'd0);
    chk("t6_oor_ss", 32'(ss3_low), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
